// File: rtl/pipeline_pkg.sv
// Shared front-end pipeline definitions: fetch FSM encoding, the canonical NOP
// and a word-alignment helper for redirect targets.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Redirect targets are forced onto a word boundary; the caller truncates to PC_W.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/ack bus between the fetch sequencer (master)
// and instruction memory (slave).
interface pc_fetch_sequencer_if #(
  parameter int PC_W = 9
) ();

  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word that arrives while the
// IF/ID output is stalled and already occupied.
module fetch_skid_buf #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic [PC_W-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_reg;
  logic [PC_W-1:0] pc_reg;
  logic [31:0]     instr_reg;

  // Load wins over drain so a same-cycle refill is never lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents fetched words to IF/ID and flushes the pipeline on taken redirects.
module pc_fetch_sequencer
  import pipeline_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        PcSel,
  input  logic [31:0]                 BrPC,
  pc_fetch_sequencer_if.master        imem,
  output logic                        if_valid,
  output logic [PC_W-1:0]             if_pc,
  output logic [31:0]                 if_instr,
  output logic                        flush_ifid,
  output logic                        flush_idex,
  output logic                        misalign_err
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] addr_reg, addr_next;
  logic            req_reg, req_next;
  logic            if_valid_reg, if_valid_next;
  logic [PC_W-1:0] if_pc_reg, if_pc_next;
  logic [31:0]     if_instr_reg, if_instr_next;
  logic            misalign_reg, misalign_next;

  logic [31:0]     target_word;
  logic [PC_W-1:0] target_pc;
  logic            unused_target_hi;
  logic            ack_live;
  logic            skid_load, skid_drain, skid_valid;
  logic [PC_W-1:0] skid_pc;
  logic [31:0]     skid_instr;

  assign target_word      = word_align(BrPC);
  assign target_pc        = target_word[PC_W-1:0];
  assign unused_target_hi = ^target_word[31:PC_W];

  // An ack only counts against a request we are actually holding; strays are ignored.
  assign ack_live = req_reg & imem.ack;

  fetch_skid_buf #(
    .PC_W(PC_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .drain      (skid_drain),
    .load_pc    (pc_reg),
    .load_instr (imem.rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (PcSel) begin
          // Without an ack the old request is still in flight and must be drained.
          state_next = ack_live ? FETCH : SQUASH;
        end else if (ack_live && stall) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (PcSel || !stall) begin
          state_next = FETCH;
        end
      end
      SQUASH: begin
        if (ack_live) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next       = pc_reg;
    if_valid_next = if_valid_reg;
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    misalign_next = misalign_reg | (PcSel & (BrPC[1:0] != 2'b00));

    case (state_reg)
      FETCH: begin
        if (ack_live) begin
          pc_next = pc_reg + PC_STEP;
          if (!stall || !if_valid_reg) begin
            if_valid_next = 1'b1;
            if_pc_next    = pc_reg;
            if_instr_next = imem.rdata;
          end else begin
            skid_load = 1'b1;
          end
        end else if (!stall) begin
          // The presented word is consumed this edge and nothing replaces it.
          if_valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (!stall) begin
          skid_drain    = 1'b1;
          if_valid_next = skid_valid;
          if (skid_valid) begin
            if_pc_next    = skid_pc;
            if_instr_next = skid_instr;
          end
        end
      end
      default: ;
    endcase

    // Redirect overrides everything below reset: wrong-path words are discarded.
    if (PcSel) begin
      pc_next       = target_pc;
      if_valid_next = 1'b0;
      skid_load     = 1'b0;
      skid_drain    = 1'b1;
    end

    req_next  = (state_next == FETCH) || (state_next == SQUASH);
    addr_next = (state_next == SQUASH) ? addr_reg : pc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      req_reg      <= 1'b0;
      if_valid_reg <= 1'b0;
      if_pc_reg    <= '0;
      if_instr_reg <= '0;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      addr_reg     <= addr_next;
      req_reg      <= req_next;
      if_valid_reg <= if_valid_next;
      if_pc_reg    <= if_pc_next;
      if_instr_reg <= if_instr_next;
      misalign_reg <= misalign_next;
    end
  end

  assign imem.req     = req_reg;
  assign imem.addr    = addr_reg;
  assign if_valid     = if_valid_reg;
  assign if_pc        = if_pc_reg;
  assign if_instr     = if_instr_reg;
  assign misalign_err = misalign_reg;
  assign flush_ifid   = PcSel & reset;
  assign flush_idex   = PcSel & reset;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench for pc_fetch_sequencer: an imem responder, a scoreboard of
// the expected in-order instruction stream, and a monitor that pops per consumed word.
module tb_pc_fetch_sequencer;

  localparam int PC_W = 9;
  localparam logic [PC_W-1:0] RESET_PC = 9'h000;

  typedef struct packed {
    logic [8:0]  pc;
    logic [31:0] instr;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            flush_ifid;
  logic            flush_idex;
  logic            misalign_err;

  pc_fetch_sequencer_if #(.PC_W(PC_W)) imem_bus ();

  pc_fetch_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .imem         (imem_bus),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         n_consumed = 0;
  exp_t       exp_q[$];
  bit         exp_mis = 1'b0;
  bit         stray_ack = 1'b0;
  bit         resp_tracking = 1'b0;
  int         resp_cnt = 0;
  logic [8:0] resp_addr = '0;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return {7'h55, a, 7'h2A, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream after a (re)start: consecutive words from start, modulo 2**PC_W.
  task automatic expect_from(input logic [8:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      exp_t e;
      e.pc    = start + 9'(4 * i);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    PcSel = 1'b1;
    BrPC  = tgt;
    expect_from(tgt[8:0] & 9'h1FC);
    tick();
    PcSel = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    PcSel = 1'b0;
    repeat (3) tick();
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_req", 32'(imem_bus.req), 32'd0);
    check("rst_addr", 32'(imem_bus.addr), 32'(RESET_PC));
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_flush", 32'(flush_ifid), 32'd0);
    reset = 1'b1;
    stray_ack = 1'b1;
    expect_from(RESET_PC);
    tick();
  endtask

  task automatic wait_words(input int target, input string name);
    for (int i = 0; i < 80 && n_consumed < target; i++) tick();
    check(name, 32'(n_consumed >= target), 32'd1);
  endtask

  // Memory responder: acks each request 1..3 cycles after it appears.
  initial begin
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_bus.ack = 1'b0;
      if (!reset) begin
        resp_tracking = 1'b0;
      end else if (!imem_bus.req) begin
        if (stray_ack) begin
          imem_bus.ack   = 1'b1;
          imem_bus.rdata = 32'hDEAD_BEEF;
          stray_ack      = 1'b0;
        end
      end else if (!resp_tracking) begin
        resp_tracking = 1'b1;
        resp_cnt      = $urandom_range(0, 2);
        resp_addr     = imem_bus.addr;
      end else begin
        check("addr_stable", 32'(imem_bus.addr), 32'(resp_addr));
        if (resp_cnt == 0) begin
          imem_bus.ack   = 1'b1;
          imem_bus.rdata = mem_word(resp_addr);
          resp_tracking  = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
    end
  end

  // Monitor: a word is consumed when presented with no stall and no redirect.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("flush_ifid", 32'(flush_ifid), 32'(PcSel));
        check("flush_idex", 32'(flush_idex), 32'(PcSel));
        check("misalign", 32'(misalign_err), 32'(exp_mis));
        if (if_valid && !stall && !PcSel) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stream_empty actual_pc=%h expected=none", if_pc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("if_pc", 32'(if_pc), 32'(e.pc));
            check("if_instr", if_instr, e.instr);
            n_consumed++;
          end
        end
        if (PcSel && BrPC[1:0] != 2'b00) exp_mis = 1'b1;
      end else begin
        exp_mis = 1'b0;
      end
    end
  end

  initial begin
    bit          ok;
    logic [8:0]  old_addr;
    logic [8:0]  hold_pc;
    logic [31:0] hold_instr;

    reset = 1'b0;
    stall = 1'b0;
    PcSel = 1'b0;
    BrPC  = '0;
    tick();
    do_reset();
    check("t1_first_addr", 32'(imem_bus.addr), 32'(RESET_PC));
    wait_words(n_consumed + 4, "t1_words");

    // Redirect while a fresh request is pending: squash, then fetch at 0x40.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_bus.req && !resp_tracking) ok = 1'b1; else tick();
    end
    check("t2_req_wait", 32'(ok), 32'd1);
    old_addr = imem_bus.addr;
    redirect(32'h40);
    check("t2_squash_req", 32'(imem_bus.req), 32'd1);
    check("t2_squash_addr", 32'(imem_bus.addr), 32'(old_addr));
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      ok = imem_bus.ack;
    end
    check("t2_ack_wait", 32'(ok), 32'd1);
    check("t2_next_req", 32'(imem_bus.req), 32'd1);
    check("t2_next_addr", 32'(imem_bus.addr), 32'h40);
    wait_words(n_consumed + 2, "t2_words");

    // Stall across an ack: presented word held, arriving word goes to the skid.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (if_valid && imem_bus.req && !resp_tracking) ok = 1'b1; else tick();
    end
    check("t3_wait", 32'(ok), 32'd1);
    stall = 1'b1;
    hold_pc = if_pc;
    hold_instr = if_instr;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_hold_valid", 32'(if_valid), 32'd1);
      check("t3_hold_pc", 32'(if_pc), 32'(hold_pc));
      check("t3_hold_instr", if_instr, hold_instr);
    end
    stall = 1'b0;
    tick();
    check("t3_skid_valid", 32'(if_valid), 32'd1);
    check("t3_skid_pc", 32'(if_pc), 32'(hold_pc + 9'd4));
    wait_words(n_consumed + 2, "t3_words");

    // Wrap at the top of the PC space, then redirect coinciding with an ack.
    redirect(32'h1F8);
    wait_words(n_consumed + 4, "t5_wrap_words");
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (reset && imem_bus.req && resp_tracking && resp_cnt == 0) ok = 1'b1; else tick();
    end
    check("t5_ack_wait", 32'(ok), 32'd1);
    redirect(32'h80);
    check("t5_req", 32'(imem_bus.req), 32'd1);
    check("t5_addr", 32'(imem_bus.addr), 32'h80);
    wait_words(n_consumed + 2, "t5_words");

    // Misaligned target: truncated fetch address, sticky error.
    redirect(32'h102);
    check("t4_misalign_set", 32'(misalign_err), 32'd1);
    wait_words(n_consumed + 3, "t4_words");
    check("t4_sticky", 32'(misalign_err), 32'd1);

    // Reset while a request is outstanding; stray ack during IDLE is ignored.
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_bus.req && resp_tracking) ok = 1'b1; else tick();
    end
    check("t6_wait", 32'(ok), 32'd1);
    do_reset();
    check("t6_first_req", 32'(imem_bus.req), 32'd1);
    check("t6_first_addr", 32'(imem_bus.addr), 32'(RESET_PC));
    wait_words(n_consumed + 3, "t6_words");

    for (int c = 0; c < 2000; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0) redirect($urandom);
        else redirect($urandom & 32'hFFFF_FFFC);
      end else begin
        tick();
      end
    end
    stall = 1'b0;
    wait_words(n_consumed + 2, "tail_words");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
